// File: rtl/conv_accum_unit.sv
// Multi-beat convolution accumulator: per-kernel dot products over CONV_SIZE window
// elements, accumulated across input-channel beats, then biased, saturated and optionally ReLU'd.
module conv_accum_unit #(
    parameter int CONV_SIZE      = 9,
    parameter int KERNEL_NUM     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int FRACTION_WIDTH = 15,
    parameter int ACC_WIDTH      = DATA_WIDTH + 16,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                                                i_clock,
    input  logic                                                i_reset,
    input  logic                                                i_valid,
    output logic                                                o_ready,
    input  logic [CONV_SIZE-1:0][DATA_WIDTH-1:0]                i_input_feature,
    input  logic [KERNEL_NUM-1:0][CONV_SIZE-1:0][DATA_WIDTH-1:0] i_kernel,
    input  logic [CNT_WIDTH-1:0]                                i_channel_count,
    input  logic [KERNEL_NUM-1:0][DATA_WIDTH-1:0]               i_bias,
    input  logic                                                i_relu_en,
    input  logic                                                i_abort,
    input  logic                                                i_clear_overflow,
    output logic                                                o_valid,
    input  logic                                                i_ready,
    output logic [KERNEL_NUM-1:0][DATA_WIDTH-1:0]               o_result,
    output logic                                                o_overflow
);

    localparam int PW  = 2 * DATA_WIDTH;
    localparam int AW1 = ACC_WIDTH + 1;
    localparam int SW  = ACC_WIDTH + 2;

    localparam logic signed [PW-1:0]  P_MAX = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0]  P_MIN = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [SW-1:0]  S_MAX = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0]  S_MIN = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [AW1-1:0] A_MAX = {{2{1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [AW1-1:0] A_MIN = {{2{1'b1}}, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] sat_prod(input logic signed [PW-1:0] v);
        if (v > P_MAX)      sat_prod = P_MAX[DATA_WIDTH-1:0];
        else if (v < P_MIN) sat_prod = P_MIN[DATA_WIDTH-1:0];
        else                sat_prod = v[DATA_WIDTH-1:0];
    endfunction

    function automatic logic ovf_prod(input logic signed [PW-1:0] v);
        ovf_prod = (v > P_MAX) || (v < P_MIN);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat_sum(input logic signed [SW-1:0] v);
        if (v > S_MAX)      sat_sum = S_MAX[DATA_WIDTH-1:0];
        else if (v < S_MIN) sat_sum = S_MIN[DATA_WIDTH-1:0];
        else                sat_sum = v[DATA_WIDTH-1:0];
    endfunction

    function automatic logic ovf_sum(input logic signed [SW-1:0] v);
        ovf_sum = (v > S_MAX) || (v < S_MIN);
    endfunction

    function automatic logic [ACC_WIDTH-1:0] sat_acc(input logic signed [AW1-1:0] v);
        if (v > A_MAX)      sat_acc = A_MAX[ACC_WIDTH-1:0];
        else if (v < A_MIN) sat_acc = A_MIN[ACC_WIDTH-1:0];
        else                sat_acc = v[ACC_WIDTH-1:0];
    endfunction

    function automatic logic ovf_acc(input logic signed [AW1-1:0] v);
        ovf_acc = (v > A_MAX) || (v < A_MIN);
    endfunction

    state_t                          state_r, state_next_s;
    logic [CNT_WIDTH-1:0]            count_r, beat_idx_r, count_in_s;
    logic signed [ACC_WIDTH-1:0]     acc_r [KERNEL_NUM];
    logic [KERNEL_NUM-1:0][DATA_WIDTH-1:0] result_r;
    logic                            overflow_r;

    logic signed [PW-1:0]            prod_w_s   [KERNEL_NUM][CONV_SIZE];
    logic signed [DATA_WIDTH-1:0]    prod_s     [KERNEL_NUM][CONV_SIZE];
    logic signed [ACC_WIDTH-1:0]     beat_sum_s [KERNEL_NUM];
    logic signed [AW1-1:0]           acc_sum_s  [KERNEL_NUM];
    logic signed [ACC_WIDTH-1:0]     acc_next_s [KERNEL_NUM];
    logic signed [SW-1:0]            fin_sum_s  [KERNEL_NUM];
    logic signed [DATA_WIDTH-1:0]    fin_sat_s  [KERNEL_NUM];
    logic [DATA_WIDTH-1:0]           res_next_s [KERNEL_NUM];
    logic                            prod_ovf_s, acc_ovf_s, fin_ovf_s, ovf_set_s;
    logic                            first_s, take_acc_s, take_final_s, abort_s;

    // Datapath: saturated fixed-point products, beat sums, next accumulator and final result.
    always_comb begin
        prod_ovf_s = 1'b0;
        acc_ovf_s  = 1'b0;
        fin_ovf_s  = 1'b0;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            beat_sum_s[k] = '0;
            for (int c = 0; c < CONV_SIZE; c++) begin
                prod_w_s[k][c] = ($signed({{DATA_WIDTH{i_input_feature[c][DATA_WIDTH-1]}}, i_input_feature[c]})
                                * $signed({{DATA_WIDTH{i_kernel[k][c][DATA_WIDTH-1]}}, i_kernel[k][c]}))
                                >>> FRACTION_WIDTH;
                prod_s[k][c]   = sat_prod(prod_w_s[k][c]);
                prod_ovf_s     = prod_ovf_s | ovf_prod(prod_w_s[k][c]);
                beat_sum_s[k]  = beat_sum_s[k] + ACC_WIDTH'(prod_s[k][c]);
            end
            acc_sum_s[k]  = AW1'(acc_r[k]) + AW1'(beat_sum_s[k]);
            acc_next_s[k] = sat_acc(acc_sum_s[k]);
            acc_ovf_s     = acc_ovf_s | ovf_acc(acc_sum_s[k]);
            // Final sum is formed wide so the accumulator and bias never wrap before saturation.
            fin_sum_s[k]  = SW'(acc_r[k]) + SW'(beat_sum_s[k]) + SW'($signed(i_bias[k]));
            fin_sat_s[k]  = sat_sum(fin_sum_s[k]);
            fin_ovf_s     = fin_ovf_s | ovf_sum(fin_sum_s[k]);
            res_next_s[k] = (i_relu_en && fin_sat_s[k][DATA_WIDTH-1]) ? '0 : fin_sat_s[k];
        end
    end

    // Next-state and control strobes for beat acceptance, abort and result handoff.
    always_comb begin
        state_next_s = state_r;
        first_s      = 1'b0;
        take_acc_s   = 1'b0;
        take_final_s = 1'b0;
        abort_s      = 1'b0;
        count_in_s   = (i_channel_count == '0) ? CNT_ONE : i_channel_count;
        case (state_r)
            IDLE: begin
                if (i_valid) begin
                    first_s = 1'b1;
                    if (count_in_s == CNT_ONE) begin
                        take_final_s = 1'b1;
                        state_next_s = OUTPUT;
                    end else begin
                        take_acc_s   = 1'b1;
                        state_next_s = ACCUM;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCUM: begin
                if (i_abort) begin
                    abort_s      = 1'b1;
                    state_next_s = IDLE;
                end else if (i_valid) begin
                    if (beat_idx_r == count_r - CNT_ONE) begin
                        take_final_s = 1'b1;
                        state_next_s = OUTPUT;
                    end else begin
                        take_acc_s   = 1'b1;
                        state_next_s = ACCUM;
                    end
                end else begin
                    state_next_s = ACCUM;
                end
            end
            OUTPUT: begin
                if (i_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = OUTPUT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        ovf_set_s = (take_acc_s & (prod_ovf_s | acc_ovf_s)) | (take_final_s & (prod_ovf_s | fin_ovf_s));
    end

    // State, counters, accumulators, result and sticky overflow registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r    <= IDLE;
            count_r    <= '0;
            beat_idx_r <= '0;
            result_r   <= '0;
            overflow_r <= 1'b0;
            for (int k = 0; k < KERNEL_NUM; k++) begin
                acc_r[k] <= '0;
            end
        end else begin
            state_r <= state_next_s;
            if (first_s) begin
                count_r <= count_in_s;
            end
            if (take_final_s || abort_s) begin
                beat_idx_r <= '0;
            end else if (take_acc_s) begin
                beat_idx_r <= beat_idx_r + CNT_ONE;
            end
            for (int k = 0; k < KERNEL_NUM; k++) begin
                if (take_final_s || abort_s) begin
                    acc_r[k] <= '0;
                end else if (take_acc_s) begin
                    acc_r[k] <= acc_next_s[k];
                end
                if (take_final_s) begin
                    result_r[k] <= res_next_s[k];
                end
            end
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (i_clear_overflow) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign o_valid    = (state_r == OUTPUT);
    assign o_ready    = (state_r != OUTPUT);
    assign o_result   = result_r;
    assign o_overflow = overflow_r;

endmodule

// File: tb/tb_conv_accum_unit.sv
// Self-checking bench for conv_accum_unit: directed cases with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_conv_accum_unit;

    localparam int CS = 9;
    localparam int KN = 4;
    localparam int DW = 32;
    localparam int FW = 15;
    localparam int AW = 48;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_valid = 1'b0, i_relu_en = 1'b0, i_abort = 1'b0, i_clear = 1'b0, i_ready = 1'b1;
    logic [CW-1:0] cc = 8'd1;
    logic signed [DW-1:0] feat [CS];
    logic signed [DW-1:0] kern [KN][CS];
    logic signed [DW-1:0] bias [KN];
    logic [CS-1:0][DW-1:0]         feat_p;
    logic [KN-1:0][CS-1:0][DW-1:0] kern_p;
    logic [KN-1:0][DW-1:0]         bias_p;
    logic o_ready, o_valid, o_overflow;
    logic [KN-1:0][DW-1:0] o_result;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: phase 0 = waiting for first beat, 1 = mid-accumulation, 2 = result pending.
    int     m_phase = 0;
    int     m_cnt   = 0;
    int     m_idx   = 0;
    longint m_acc [KN];
    longint m_res [KN];
    bit     m_ovf   = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        for (int c = 0; c < CS; c++) feat_p[c] = feat[c];
        for (int k = 0; k < KN; k++) begin
            bias_p[k] = bias[k];
            for (int c = 0; c < CS; c++) kern_p[k][c] = kern[k][c];
        end
    end

    conv_accum_unit #(
        .CONV_SIZE(CS), .KERNEL_NUM(KN), .DATA_WIDTH(DW),
        .FRACTION_WIDTH(FW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_input_feature(feat_p), .i_kernel(kern_p), .i_channel_count(cc),
        .i_bias(bias_p), .i_relu_en(i_relu_en), .i_abort(i_abort),
        .i_clear_overflow(i_clear), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_overflow(o_overflow)
    );

    function automatic longint smax(input int w);
        return (longint'(1) << (w - 1)) - longint'(1);
    endfunction

    function automatic longint satw(input longint v, input int w);
        if (v > smax(w)) return smax(w);
        else if (v < -smax(w) - longint'(1)) return -smax(w) - longint'(1);
        else return v;
    endfunction

    function automatic bit ovw(input longint v, input int w);
        return (v > smax(w)) || (v < -smax(w) - longint'(1));
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        longint bs [KN];
        longint p, s;
        bit pov, nov;
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_idx = 0; m_ovf = 1'b0;
            for (int k = 0; k < KN; k++) begin m_acc[k] = 0; m_res[k] = 0; end
            return;
        end
        pov = 1'b0;
        nov = 1'b0;
        for (int k = 0; k < KN; k++) begin
            bs[k] = 0;
            for (int c = 0; c < CS; c++) begin
                p = (longint'(feat[c]) * longint'(kern[k][c])) >>> FW;
                pov |= ovw(p, DW);
                bs[k] += satw(p, DW);
            end
        end
        if (m_phase == 2) begin
            if (i_ready) m_phase = 0;
        end else if (m_phase == 1 && i_abort) begin
            for (int k = 0; k < KN; k++) m_acc[k] = 0;
            m_idx = 0;
            m_phase = 0;
        end else if (i_valid) begin
            nov = pov;
            if (m_phase == 0) begin
                m_cnt = (cc == 8'd0) ? 1 : int'(cc);
                m_idx = 0;
            end
            if (m_idx == m_cnt - 1) begin
                for (int k = 0; k < KN; k++) begin
                    s = m_acc[k] + bs[k] + longint'(bias[k]);
                    nov |= ovw(s, DW);
                    m_res[k] = satw(s, DW);
                    if (i_relu_en && m_res[k] < 0) m_res[k] = 0;
                    m_acc[k] = 0;
                end
                m_idx = 0;
                m_phase = 2;
            end else begin
                for (int k = 0; k < KN; k++) begin
                    nov |= ovw(m_acc[k] + bs[k], AW);
                    m_acc[k] = satw(m_acc[k] + bs[k], AW);
                end
                m_idx++;
                m_phase = 1;
            end
        end
        if (nov) m_ovf = 1'b1;
        else if (i_clear) m_ovf = 1'b0;
    endtask

    task automatic compare_all();
        chk("o_valid", longint'(o_valid), longint'(m_phase == 2));
        chk("o_ready", longint'(o_ready), longint'(m_phase != 2));
        chk("o_overflow", longint'(o_overflow), longint'(m_ovf));
        for (int k = 0; k < KN; k++)
            chk($sformatf("o_result[%0d]", k), longint'($signed(o_result[k])), m_res[k]);
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic fill(input int fv, input int kv, input int bv);
        for (int c = 0; c < CS; c++) feat[c] = fv;
        for (int k = 0; k < KN; k++) begin
            bias[k] = bv;
            for (int c = 0; c < CS; c++) kern[k][c] = kv;
        end
    endtask

    task automatic send_n(input int n, input int cnt, input bit relu);
        for (int i = 0; i < n; i++) begin
            i_valid = 1'b1; cc = CW'(cnt); i_relu_en = relu;
            cycle();
        end
        i_valid = 1'b0;
    endtask

    task automatic res_is(input string nm, input longint exp);
        chk({nm, "_valid"}, longint'(o_valid), 64'sd1);
        chk({nm, "_model"}, m_res[0], exp);
        for (int k = 0; k < KN; k++)
            chk($sformatf("%s_res[%0d]", nm, k), longint'($signed(o_result[k])), exp);
    endtask

    function automatic logic signed [DW-1:0] rand_word();
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) return 32'sh7fffffff;
        else if (r == 1) return 32'sh80000000;
        else return $signed(32'($urandom_range(0, 131071))) - 32'sd65536;
    endfunction

    initial begin
        fill(0, 0, 0);
        for (int k = 0; k < KN; k++) begin m_acc[k] = 0; m_res[k] = 0; end
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        chk("reset_ready", longint'(o_ready), 64'sd1);
        chk("reset_valid", longint'(o_valid), 64'sd0);
        chk("reset_ovf", longint'(o_overflow), 64'sd0);

        // Single-beat result with latency one.
        fill(32768, 16384, 0);
        send_n(1, 1, 1'b0);
        res_is("single", 64'sd147456);
        cycle();

        // Three beats with bias, then hold under backpressure.
        i_ready = 1'b0;
        fill(32768, 16384, 32768);
        send_n(3, 3, 1'b0);
        res_is("three", 64'sd475136);
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            cycle();
            chk("hold_ready", longint'(o_ready), 64'sd0);
            res_is("hold", 64'sd475136);
        end
        i_valid = 1'b0; i_ready = 1'b1;
        cycle();
        chk("release_valid", longint'(o_valid), 64'sd0);

        // ReLU clamp and the unclamped negative result.
        fill(32768, -16384, 0);
        send_n(1, 1, 1'b1);
        res_is("relu", 64'sd0);
        chk("relu_ovf", longint'(o_overflow), 64'sd0);
        cycle();
        send_n(1, 1, 1'b0);
        res_is("neg", -64'sd147456);
        cycle();

        // Product saturation and sticky overflow.
        fill(32'sh7fffffff, 32'sh7fffffff, 0);
        send_n(1, 1, 1'b0);
        res_is("sat", 64'sd2147483647);
        chk("sat_ovf", longint'(o_overflow), 64'sd1);
        for (int i = 0; i < 4; i++) cycle();
        chk("sticky_ovf", longint'(o_overflow), 64'sd1);
        i_clear = 1'b1; cycle(); i_clear = 1'b0;
        chk("cleared_ovf", longint'(o_overflow), 64'sd0);

        // Abort with a same-cycle beat, then a clean single beat.
        fill(32768, 16384, 0);
        send_n(2, 4, 1'b0);
        i_abort = 1'b1; i_valid = 1'b1;
        cycle();
        i_abort = 1'b0; i_valid = 1'b0;
        chk("abort_valid", longint'(o_valid), 64'sd0);
        send_n(1, 1, 1'b0);
        res_is("after_abort", 64'sd147456);
        cycle();

        // Asynchronous reset while a result is pending.
        i_ready = 1'b0;
        send_n(1, 1, 1'b0);
        res_is("pre_rst", 64'sd147456);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", longint'(o_valid), 64'sd0);
        chk("async_res", longint'($signed(o_result[0])), 64'sd0);
        cycle();
        rst = 1'b0; i_ready = 1'b1;
        cycle();
        chk("post_rst_ready", longint'(o_ready), 64'sd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            i_valid   = ($urandom_range(0, 9) < 7);
            cc        = CW'($urandom_range(0, 4));
            i_relu_en = $urandom_range(0, 1) == 1;
            i_abort   = ($urandom_range(0, 19) == 0);
            i_ready   = ($urandom_range(0, 9) < 6);
            i_clear   = ($urandom_range(0, 29) == 0);
            for (int c = 0; c < CS; c++) feat[c] = rand_word();
            for (int k = 0; k < KN; k++) begin
                bias[k] = ($urandom_range(0, 19) == 0) ? 32'sh7fffffff
                        : $signed(32'($urandom_range(0, 65535))) - 32'sd32768;
                for (int c = 0; c < CS; c++) kern[k][c] = rand_word();
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_accum_unit.md
CONV_ACCUM_UNIT -- requirements
Module: conv_accum_unit

Interface
REQ-001 SHALL have parameter CONV_SIZE, default 9, meaning window elements per beat.
REQ-002 SHALL have parameter KERNEL_NUM, default 4, meaning parallel output channels (kernels).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning signed fixed-point word width.
REQ-004 SHALL have parameter FRACTION_WIDTH, default 15, meaning fractional bits (Q format).
REQ-005 SHALL have parameter ACC_WIDTH, default DATA_WIDTH+16, meaning signed accumulator width.
REQ-006 SHALL have parameter CNT_WIDTH, default 8, meaning width of the input-channel count.
REQ-007 SHALL have port i_clock  in  1  sole clock, rising edge; reset is asynchronous and active-high.
REQ-008 SHALL have port i_reset  in  1  asynchronous active-high reset.
REQ-009 SHALL have port i_valid  in  1  input beat valid.
REQ-010 SHALL have port o_ready  out  1  input beat ready.
REQ-011 SHALL have port i_input_feature  in  CONV_SIZE x DATA_WIDTH  window.
REQ-012 SHALL have port i_kernel  in  KERNEL_NUM x CONV_SIZE x DATA_WIDTH  weights.
REQ-013 SHALL have port i_channel_count  in  CNT_WIDTH  beats per result; sampled on first beat.
REQ-014 SHALL have port i_bias  in  KERNEL_NUM x DATA_WIDTH  per-kernel bias; sampled on final beat.
REQ-015 SHALL have port i_relu_en  in  1  ReLU enable; sampled on final beat.
REQ-016 SHALL have port i_abort  in  1  discard partial accumulation.
REQ-017 SHALL have port i_clear_overflow  in  1  clear sticky overflow.
REQ-018 SHALL have port o_valid  out  1  result valid.
REQ-019 SHALL have port i_ready  in  1  downstream ready.
REQ-020 SHALL have port o_result  out  KERNEL_NUM x DATA_WIDTH  results.
REQ-021 SHALL have port o_overflow  out  1  sticky saturation flag.

Function
REQ-022 States SHALL be IDLE, ACCUM, OUTPUT; o_ready SHALL be 1 in IDLE and ACCUM, 0 in OUTPUT.
REQ-023 A beat SHALL be accepted only on a rising edge with i_valid && o_ready.
REQ-024 Per product: signed full-width multiply, arithmetic shift right FRACTION_WIDTH, saturate to DATA_WIDTH; saturation sets o_overflow.
REQ-025 Beat sum per kernel SHALL be the sum of CONV_SIZE saturated products, computed in ACC_WIDTH without wrap.
REQ-026 Accumulator per kernel SHALL add the beat sum on each accepted beat, saturating at ACC_WIDTH limits and setting o_overflow.
REQ-027 First beat in IDLE SHALL load count = i_channel_count (0 treated as 1), zero-based beat counter, and go ACCUM unless it is also the final beat.
REQ-028 Final beat (beat counter reaches count-1) SHALL load o_result[k] = sat_DATA_WIDTH(acc[k] + beat_sum[k] + i_bias[k]), ReLU applied if i_relu_en (negative -> 0), clear accumulators, go OUTPUT.
REQ-029 o_valid SHALL assert the cycle after the final beat is accepted (latency 1) and equal 1 exactly in OUTPUT.
REQ-030 o_result and o_valid SHALL hold stable in OUTPUT until i_ready; on o_valid && i_ready SHALL go IDLE.
REQ-031 Output saturation in REQ-028 SHALL set o_overflow; ReLU clamping SHALL not.
REQ-032 i_abort in ACCUM SHALL clear accumulators and counter and go IDLE; a same-cycle beat SHALL be discarded; i_abort in IDLE/OUTPUT SHALL have no effect.
REQ-033 o_overflow SHALL be sticky; i_clear_overflow clears it; same-cycle new overflow SHALL win over clear.
REQ-034 i_channel_count changes while in ACCUM SHALL be ignored.

Reset
REQ-035 i_reset asserted SHALL immediately force IDLE, o_valid=0, o_ready=1 after release, o_result=0, o_overflow=0, accumulators and counter 0, independent of i_clock.
REQ-036 Reset mid-ACCUM or mid-OUTPUT SHALL discard all partial and pending results.

Verification
REQ-037 Count=1, all features 32768 (1.0), all kernels 16384 (0.5), bias 0 -> o_result=147456 (4.5) all kernels, o_valid one cycle after beat.
REQ-038 Count=3, same data each beat, bias 32768 -> o_result=475136 (14.5) after third beat; o_ready held 0 while i_ready=0 for 5 cycles, result stable.
REQ-039 Count=1, kernels -16384, i_relu_en=1 -> o_result=0, o_overflow=0; with i_relu_en=0 -> -147456.
REQ-040 Features 0x7FFFFFFF, kernels 0x7FFFFFFF -> product saturates, o_result=0x7FFFFFFF, o_overflow=1 until i_clear_overflow pulse.
REQ-041 Count=4, i_abort after beat 2, then count=1 beat as REQ-037 -> 147456 (no stale accumulation).
REQ-042 Assert i_reset asynchronously during OUTPUT -> o_valid and o_result drop to 0 before next clock edge.
